// File: rtl/instruction_fetcher.sv
// Fetch stage: PC, direct-mapped i-cache and miss fill. Emits one (inst, pc) per cycle.
// Latency: a cache hit is emitted on the next edge. A miss is emitted on the edge after the memory response.
// Backpressure: queue_is_full stops new lookups. A response already in flight is still emitted, using the queue's 2-slot slack.
//
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   rdy                            global ready; 0 freezes everything except clear/reset
//   clear, clear_pc                redirect pulse and target (target low bits are ignored)
//   queue_is_full                  inhibits new cache lookups
//   IF_inst_valid/IF_inst/IF_pc    fetched instruction, one pulse per instruction
//   mem_req_valid/mem_req_addr     miss request, held until the response arrives
//   mem_resp_valid/mem_resp_inst   one-cycle response pulse from the memory controller
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  input  logic        queue_is_full,
  output logic        IF_inst_valid,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_inst
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic                if_vld_q, if_vld_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic [31:0]         if_pc_q, if_pc_d;
  logic                req_vld_q, req_vld_d;
  logic [31:0]         req_addr_q, req_addr_d;
  logic [LINES-1:0]    cache_vld_q, cache_vld_d;
  logic [TAG_W-1:0]    cache_tag_q [LINES];
  logic [TAG_W-1:0]    cache_tag_d [LINES];
  logic [31:0]         cache_dat_q [LINES];
  logic [31:0]         cache_dat_d [LINES];

  logic [ICACHE_IDX_W-1:0] look_idx;
  logic [TAG_W-1:0]        look_tag;
  logic                    hit;
  logic [ICACHE_IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    fill_en;

  assign look_idx = pc_q[ICACHE_IDX_W+1:2];
  assign look_tag = pc_q[31:ICACHE_IDX_W+2];
  assign hit      = cache_vld_q[look_idx] && (cache_tag_q[look_idx] == look_tag);

  // A response always belongs to the outstanding request address, not the current PC.
  // After a redirect the two differ.
  assign fill_idx = req_addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag = req_addr_q[31:ICACHE_IDX_W+2];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_vld_d    = if_vld_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    req_vld_d   = req_vld_q;
    req_addr_d  = req_addr_q;
    cache_vld_d = cache_vld_q;
    cache_tag_d = cache_tag_q;
    cache_dat_d = cache_dat_q;
    fill_en     = 1'b0;

    if (clear) begin
      // A redirect overrides rdy. Any response arriving alongside it still fills the cache,
      // so the single outstanding request is never lost.
      pc_d     = clear_pc & ~32'h3;
      if_vld_d = 1'b0;
      if (state_q != S_IDLE) begin
        if (mem_resp_valid) begin
          fill_en   = 1'b1;
          req_vld_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_FLUSH;
        end
      end
    end else if (rdy) begin
      if_vld_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!queue_is_full) begin
            if (hit) begin
              if_vld_d  = 1'b1;
              if_inst_d = cache_dat_q[look_idx];
              if_pc_d   = pc_q;
              pc_d      = pc_q + 32'd4;
            end else begin
              req_vld_d  = 1'b1;
              req_addr_d = pc_q;
              state_d    = S_WAIT_MEM;
            end
          end
        end
        S_WAIT_MEM: begin
          if (mem_resp_valid) begin
            fill_en   = 1'b1;
            if_vld_d  = 1'b1;
            if_inst_d = mem_resp_inst;
            if_pc_d   = pc_q;
            pc_d      = pc_q + 32'd4;
            req_vld_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
        S_FLUSH: begin
          // The stale response is cached but not emitted.
          if (mem_resp_valid) begin
            fill_en   = 1'b1;
            req_vld_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (fill_en) begin
      cache_vld_d[fill_idx] = 1'b1;
      cache_tag_d[fill_idx] = fill_tag;
      cache_dat_d[fill_idx] = mem_resp_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      if_vld_q    <= 1'b0;
      if_inst_q   <= 32'h0;
      if_pc_q     <= 32'h0;
      req_vld_q   <= 1'b0;
      req_addr_q  <= 32'h0;
      cache_vld_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        cache_tag_q[i] <= '0;
        cache_dat_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_vld_q    <= if_vld_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      req_vld_q   <= req_vld_d;
      req_addr_q  <= req_addr_d;
      cache_vld_q <= cache_vld_d;
      for (int i = 0; i < LINES; i++) begin
        cache_tag_q[i] <= cache_tag_d[i];
        cache_dat_q[i] <= cache_dat_d[i];
      end
    end
  end

  assign IF_inst_valid = if_vld_q;
  assign IF_inst       = if_inst_q;
  assign IF_pc         = if_pc_q;
  assign mem_req_valid = req_vld_q;
  assign mem_req_addr  = req_addr_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, queue_is_full, mem_resp_valid;
  logic [31:0] clear_pc, mem_resp_inst;
  logic        IF_inst_valid, mem_req_valid;
  logic [31:0] IF_inst, IF_pc, mem_req_addr;

  int tests  = 0;
  int failed = 0;

  // Random-phase state
  int          dly, emits;
  bit          armed, a_rdy, a_clr, a_full, a_resp;
  logic [31:0] a_cpc, exp_pc;
  logic        p_vld, p_req;
  logic [31:0] p_inst, p_pc, p_addr;

  always #5 clk = ~clk;

  instruction_fetcher #(.RESET_PC(32'h0), .ICACHE_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .clear_pc(clear_pc),
    .queue_is_full(queue_is_full),
    .IF_inst_valid(IF_inst_valid), .IF_inst(IF_inst), .IF_pc(IF_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_inst(mem_resp_inst)
  );

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h0001_0001) ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] inst);
    mem_resp_valid = 1'b1;
    mem_resp_inst  = inst;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic do_clear(input logic [31:0] tgt);
    clear    = 1'b1;
    clear_pc = tgt;
    tick();
    clear    = 1'b0;
  endtask

  task automatic chk_emit(input string tag, input logic [31:0] pc);
    chk1({tag, "_vld"}, IF_inst_valid, 1'b1);
    chk({tag, "_pc"}, IF_pc, pc);
    chk({tag, "_inst"}, IF_inst, mem_f(pc));
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk1({tag, "_vld"}, IF_inst_valid, 1'b0);
    chk1({tag, "_req"}, mem_req_valid, 1'b1);
    chk({tag, "_addr"}, mem_req_addr, addr);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; clear_pc = 32'h0; queue_is_full = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_inst = 32'h0;
    #12;
    chk1("rst_vld", IF_inst_valid, 1'b0);
    chk("rst_inst", IF_inst, 32'h0);
    chk("rst_pc", IF_pc, 32'h0);
    chk1("rst_req", mem_req_valid, 1'b0);
    chk("rst_addr", mem_req_addr, 32'h0);
    tick();
    rst = 1'b1;

    // Cold miss at 0, response three cycles after the request
    tick();
    chk_req("cold_req", 32'h0);
    tick();
    tick();
    chk_req("cold_hold", 32'h0);
    respond(32'h0050_0093);
    chk_emit("cold_emit", 32'h0);
    chk("cold_inst_lit", IF_inst, 32'h0050_0093);
    chk1("cold_req_drop", mem_req_valid, 1'b0);
    tick();
    chk_req("cold_next", 32'h4);
    for (int a = 4; a <= 12; a += 4) begin
      respond(mem_f(a));
      chk_emit("fill_emit", a);
      tick();
      chk_req("fill_next", a + 4);
    end

    // Redirect to 0 while the miss for 0x10 is in flight, then replay hits
    do_clear(32'h0);
    chk_req("flush_hold", 32'h10);
    respond(mem_f(32'h10));
    chk1("flush_drop_vld", IF_inst_valid, 1'b0);
    chk1("flush_drop_req", mem_req_valid, 1'b0);
    for (int a = 0; a <= 8; a += 4) begin
      tick();
      chk_emit("loop_hit", a);
    end
    queue_is_full = 1'b1;
    tick();
    chk1("full_vld0", IF_inst_valid, 1'b0);
    tick();
    chk1("full_vld1", IF_inst_valid, 1'b0);
    queue_is_full = 1'b0;
    tick();
    chk_emit("full_resume", 32'hC);
    tick();
    chk_emit("flush_filled_hit", 32'h10);
    tick();
    chk_req("miss_14", 32'h14);
    for (int a = 'h14; a <= 'h1C; a += 4) begin
      respond(mem_f(a));
      chk_emit("seq_emit", a);
      tick();
      chk_req("seq_next", a + 4);
    end

    // Redirect to 0x100 while waiting on 0x20
    do_clear(32'h100);
    chk_req("r100_hold", 32'h20);
    respond(mem_f(32'h20));
    chk1("r100_drop_vld", IF_inst_valid, 1'b0);
    chk1("r100_drop_req", mem_req_valid, 1'b0);
    tick();
    chk_req("r100_req", 32'h100);
    // Redirect in the same cycle as the response: fill, no emit, no flush
    clear = 1'b1; clear_pc = 32'h20; mem_resp_valid = 1'b1; mem_resp_inst = mem_f(32'h100);
    tick();
    clear = 1'b0; mem_resp_valid = 1'b0;
    chk1("clr_resp_vld", IF_inst_valid, 1'b0);
    chk1("clr_resp_req", mem_req_valid, 1'b0);
    tick();
    chk_emit("dropped_cached_20", 32'h20);
    tick();
    chk_req("miss_24", 32'h24);
    do_clear(32'h100);
    chk_req("r100b_hold", 32'h24);
    respond(mem_f(32'h24));
    chk1("r100b_drop", IF_inst_valid, 1'b0);
    tick();
    chk_emit("hit_100", 32'h100);
    tick();
    chk_req("miss_104", 32'h104);

    // Misaligned redirect near the top of the address space, then wrap
    do_clear(32'hFFFF_FFFE);
    chk_req("wrap_hold", 32'h104);
    respond(mem_f(32'h104));
    chk1("wrap_drop", IF_inst_valid, 1'b0);
    tick();
    chk_req("wrap_req", 32'hFFFF_FFFC);
    respond(mem_f(32'hFFFF_FFFC));
    chk_emit("wrap_emit", 32'hFFFF_FFFC);
    tick();
    chk_req("wrap_zero_evicted", 32'h0);
    respond(mem_f(32'h0));
    chk_emit("wrap_zero_emit", 32'h0);

    // rdy=0 freezes everything
    rdy = 1'b0;
    repeat (3) tick();
    chk_emit("frz", 32'h0);
    chk1("frz_req", mem_req_valid, 1'b0);
    rdy = 1'b1;
    tick();
    chk_req("unfrz_miss_4", 32'h4);

    // Asynchronous reset in the middle of a miss
    #2 rst = 1'b0;
    #1;
    chk1("arst_vld", IF_inst_valid, 1'b0);
    chk("arst_inst", IF_inst, 32'h0);
    chk("arst_pc", IF_pc, 32'h0);
    chk1("arst_req", mem_req_valid, 1'b0);
    chk("arst_addr", mem_req_addr, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk_req("arst_empty_cache", 32'h0);

    // Randomized phase against a transaction-level model of the expected PC stream
    exp_pc = 32'h0; armed = 1'b0; dly = 0; emits = 0;
    p_vld = IF_inst_valid; p_inst = IF_inst; p_pc = IF_pc; p_req = mem_req_valid; p_addr = mem_req_addr;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!armed && mem_req_valid) begin
        armed = 1'b1;
        dly   = $urandom_range(0, 3);
      end
      a_rdy  = ($urandom_range(0, 9) != 0);
      a_clr  = ($urandom_range(0, 39) == 0);
      a_full = ($urandom_range(0, 3) == 0);
      a_resp = 1'b0;
      if (armed) begin
        if (dly == 0) begin
          if (a_rdy && !a_clr) begin
            a_resp = 1'b1;
            armed  = 1'b0;
          end
        end else begin
          dly--;
        end
      end
      a_cpc = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0) | 32'($urandom_range(0, 255));
      rdy = a_rdy; clear = a_clr; clear_pc = a_cpc; queue_is_full = a_full;
      mem_resp_valid = a_resp;
      mem_resp_inst  = a_resp ? mem_f(mem_req_addr) : $urandom;
      tick();
      if (a_clr) begin
        chk1("rnd_clear_vld", IF_inst_valid, 1'b0);
        exp_pc = a_cpc & ~32'h3;
      end else if (!a_rdy) begin
        chk1("rnd_frz_vld", IF_inst_valid, p_vld);
        chk("rnd_frz_inst", IF_inst, p_inst);
        chk("rnd_frz_pc", IF_pc, p_pc);
        chk1("rnd_frz_req", mem_req_valid, p_req);
        chk("rnd_frz_addr", mem_req_addr, p_addr);
      end else begin
        if (a_full && !a_resp) chk1("rnd_full_vld", IF_inst_valid, 1'b0);
        if (IF_inst_valid) begin
          chk("rnd_pc", IF_pc, exp_pc);
          chk("rnd_inst", IF_inst, mem_f(exp_pc));
          exp_pc = exp_pc + 32'd4;
          emits++;
        end
      end
      if (p_req && mem_req_valid) chk("rnd_addr_stable", mem_req_addr, p_addr);
      if (mem_req_valid) chk("rnd_addr_align", mem_req_addr & 32'h3, 32'h0);
      p_vld = IF_inst_valid; p_inst = IF_inst; p_pc = IF_pc; p_req = mem_req_valid; p_addr = mem_req_addr;
    end
    chk1("rnd_progress", emits > 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
